wb_sram_slave: RTL and testbench

- Single-port scratchpad RAM that is the slave endpoint on the shared Wishbone bus.
- Consumes the master's addr/data_write/we/stb/cyc/width signals and produces ack/data_read.
- Handles byte, half-word and word transfers with right-justified data, plus a programmable number of wait states.
- Sits directly behind the bus interconnect as the default data memory for the CPU load/store unit.

---
 rtl/wb_sram_slave.sv | 100 ++++++++++
 tb/tb_wb_sram_slave.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_sram_slave.sv
// wb_sram_slave: Wishbone scratchpad RAM slave with byte/half/word lanes and programmable wait states
// Ports: iClk/nRst clock and async active-low reset; addr/data_write/we/stb/cyc/width request in;
// ack/data_read response out; oErr sticky error flag, cleared synchronously by iErrClr.
module wb_sram_slave #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH_WORDS = 1024,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR = '0,
    parameter int WAIT_STATES = 1
) (
    input  logic                  iClk,
    input  logic                  nRst,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [DATA_WIDTH-1:0] data_write,
    input  logic                  we,
    input  logic                  stb,
    input  logic                  cyc,
    input  logic [1:0]            width,
    output logic                  ack,
    output logic [DATA_WIDTH-1:0] data_read,
    output logic                  oErr,
    input  logic                  iErrClr
);
    localparam int IW = $clog2(DEPTH_WORDS);
    localparam logic [3:0] WS_M1 = (WAIT_STATES == 0) ? 4'd0 : 4'(WAIT_STATES - 1);
    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ACK} state_t;
    state_t state_q, state_d;
    logic [ADDR_WIDTH-1:0] addr_q, a_addr;
    logic [DATA_WIDTH-1:0] wdata_q, a_wdata, wdata_sh, rd_word, rdata_q, rdata_d;
    logic [DATA_WIDTH-1:0] mem [DEPTH_WORDS];
    logic [1:0] width_q, a_width;
    logic [3:0] cnt_q, cnt_d, be;
    logic [4:0] sh;
    logic [IW-1:0] idx;
    logic we_q, a_we, ack_q, ack_d, err_q, err_d, req, idle, enter_ack, bad, wen;
    // With zero wait states ACK is entered on the capture edge itself, so the
    // request in flight is taken straight from the bus while idle.
    always_comb begin
        req = cyc && stb;
        idle = state_q == S_IDLE;
        a_addr = idle ? addr : addr_q;
        a_wdata = idle ? data_write : wdata_q;
        a_we = idle ? we : we_q;
        a_width = idle ? width : width_q;
        sh = {a_addr[1:0], 3'b000};
        idx = a_addr[IW+1:2];
        // BASE_ADDR is aligned to the RAM size, so range check is a compare of the high bits
        bad = (a_width == 2'b11) || (a_width == 2'b01 && a_addr[0]) ||
              (a_width == 2'b10 && a_addr[1:0] != 2'b00) ||
              (a_addr[ADDR_WIDTH-1:IW+2] != BASE_ADDR[ADDR_WIDTH-1:IW+2]);
        enter_ack = (idle && req && WAIT_STATES == 0) || (state_q == S_WAIT && cyc && cnt_q == 4'd0);
        state_d = idle ? (req ? (WAIT_STATES == 0 ? S_ACK : S_WAIT) : S_IDLE) :
                  state_q == S_WAIT ? (!cyc ? S_IDLE : cnt_q == 4'd0 ? S_ACK : S_WAIT) : S_IDLE;
        cnt_d = idle ? WS_M1 : (state_q == S_WAIT && cnt_q != 4'd0) ? cnt_q - 4'd1 : cnt_q;
        be = a_width == 2'b00 ? 4'b0001 << a_addr[1:0] :
             a_width == 2'b01 ? (a_addr[1] ? 4'b1100 : 4'b0011) : 4'b1111;
        wdata_sh = a_wdata << sh;
        wen = enter_ack && a_we && !bad;
        rd_word = mem[idx] >> sh;
        rdata_d = (!enter_ack || a_we || bad) ? '0 :
                  a_width == 2'b00 ? DATA_WIDTH'(rd_word[7:0]) :
                  a_width == 2'b01 ? DATA_WIDTH'(rd_word[15:0]) : rd_word;
        ack_d = enter_ack;
        // a new error on the same edge as a clear request wins
        err_d = (enter_ack && bad) || (err_q && !iErrClr);
    end
    always_ff @(posedge iClk or negedge nRst) begin
        if (!nRst) begin
            state_q <= S_IDLE;
            cnt_q <= '0;
            ack_q <= 1'b0;
            rdata_q <= '0;
            err_q <= 1'b0;
            addr_q <= '0;
            wdata_q <= '0;
            we_q <= 1'b0;
            width_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q <= cnt_d;
            ack_q <= ack_d;
            rdata_q <= rdata_d;
            err_q <= err_d;
            if (idle && req) begin
                addr_q <= addr;
                wdata_q <= data_write;
                we_q <= we;
                width_q <= width;
            end
        end
    end
    // RAM contents are deliberately not reset
    always_ff @(posedge iClk) begin
        for (int i = 0; i < 4; i++)
            if (wen && be[i]) mem[idx][8*i +: 8] <= wdata_sh[8*i +: 8];
    end
    assign ack = ack_q;
    assign data_read = rdata_q;
    assign oErr = err_q;
endmodule

// File: tb/tb_wb_sram_slave.sv
// tb_wb_sram_slave: directed self-checking bench for wb_sram_slave at 1, 3 and 0 wait states
module tb_wb_sram_slave;
    logic clk = 1'b0, rst_n = 1'b0, we = 1'b0, err_clr = 1'b0;
    logic [31:0] addr = '0, data_write = '0;
    logic [1:0] width = '0;
    logic [2:0] cyc_v = '0, stb_v = '0, ack_v, err_v;
    logic [31:0] rd_v [3];
    int checks = 0, errors = 0;
    always #5 clk = ~clk;
    wb_sram_slave #(.WAIT_STATES(1)) u0 (.iClk(clk), .nRst(rst_n), .addr(addr), .data_write(data_write),
        .we(we), .stb(stb_v[0]), .cyc(cyc_v[0]), .width(width), .ack(ack_v[0]), .data_read(rd_v[0]),
        .oErr(err_v[0]), .iErrClr(err_clr));
    wb_sram_slave #(.WAIT_STATES(3)) u1 (.iClk(clk), .nRst(rst_n), .addr(addr), .data_write(data_write),
        .we(we), .stb(stb_v[1]), .cyc(cyc_v[1]), .width(width), .ack(ack_v[1]), .data_read(rd_v[1]),
        .oErr(err_v[1]), .iErrClr(err_clr));
    wb_sram_slave #(.WAIT_STATES(0)) u2 (.iClk(clk), .nRst(rst_n), .addr(addr), .data_write(data_write),
        .we(we), .stb(stb_v[2]), .cyc(cyc_v[2]), .width(width), .ack(ack_v[2]), .data_read(rd_v[2]),
        .oErr(err_v[2]), .iErrClr(err_clr));
    // Presents a request just after a rising edge; lat counts falling edges up to and including the ack one.
    task automatic xfer(input int s, input bit w, input logic [1:0] wd, input logic [31:0] a, input logic [31:0] d,
                        input bit hold, output logic [31:0] rd, output int lat);
        addr = a;
        data_write = d;
        we = w;
        width = wd;
        cyc_v[s] = 1'b1;
        stb_v[s] = 1'b1;
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (!ack_v[s] && lat < 40);
        rd = rd_v[s];
        if (!hold) begin
            cyc_v[s] = 1'b0;
            stb_v[s] = 1'b0;
        end
        @(posedge clk);
        #1;
    endtask
    task automatic test_reset();
        cyc_v = '1;
        stb_v = '1;
        we = 1'b1;
        repeat (2) @(negedge clk);
        for (int s = 0; s < 3; s++) begin
            checks++;
            if ({ack_v[s], err_v[s], rd_v[s]} !== 34'b0) begin
                errors++;
                $display("FAIL reset dut%0d: ack=%b err=%b rd=%h expected all 0", s, ack_v[s], err_v[s], rd_v[s]);
            end
        end
        cyc_v = '0;
        stb_v = '0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask
    task automatic test_word();
        logic [31:0] rd;
        int lat;
        xfer(0, 1, 2'b10, 32'h10, 32'hDEADBEEF, 0, rd, lat);
        checks++;
        if (lat !== 3) begin errors++; $display("FAIL word_wr_latency: got %0d expected 3", lat); end
        @(negedge clk);
        checks++;
        if (ack_v[0] !== 1'b0) begin errors++; $display("FAIL ack_one_cycle: got %b expected 0", ack_v[0]); end
        @(posedge clk);
        #1;
        xfer(0, 0, 2'b10, 32'h10, 32'h0, 0, rd, lat);
        checks++;
        if (lat !== 3) begin errors++; $display("FAIL word_rd_latency: got %0d expected 3", lat); end
        checks++;
        if (rd !== 32'hDEADBEEF) begin errors++; $display("FAIL word_rd_data: got %h expected deadbeef", rd); end
        @(negedge clk);
        checks++;
        if (rd_v[0] !== 32'h0) begin errors++; $display("FAIL rd_returns_zero: got %h expected 0", rd_v[0]); end
        checks++;
        if (err_v[0] !== 1'b0) begin errors++; $display("FAIL word_no_err: got %b expected 0", err_v[0]); end
        @(posedge clk);
        #1;
    endtask
    task automatic test_bytes();
        logic [31:0] rd;
        int lat;
        for (int i = 0; i < 4; i++) xfer(0, 1, 2'b00, 32'h20 + 32'(i), {24'hABCDEF, 8'(8'h11 * (i + 1))}, 0, rd, lat);
        xfer(0, 0, 2'b10, 32'h20, 32'h0, 0, rd, lat);
        checks++;
        if (rd !== 32'h44332211) begin errors++; $display("FAIL byte_word_rd: got %h expected 44332211", rd); end
        xfer(0, 0, 2'b00, 32'h22, 32'h0, 0, rd, lat);
        checks++;
        if (rd !== 32'h00000033) begin errors++; $display("FAIL byte_rd: got %h expected 00000033", rd); end
        xfer(0, 0, 2'b01, 32'h22, 32'h0, 0, rd, lat);
        checks++;
        if (rd !== 32'h00004433) begin errors++; $display("FAIL half_rd: got %h expected 00004433", rd); end
        xfer(0, 0, 2'b00, 32'h23, 32'h0, 0, rd, lat);
        checks++;
        if (rd !== 32'h00000044) begin errors++; $display("FAIL byte_rd_lane3: got %h expected 00000044", rd); end
    endtask
    task automatic test_lanes();
        logic [31:0] rd;
        int lat;
        xfer(0, 1, 2'b10, 32'h20, 32'hFFFFFFFF, 0, rd, lat);
        xfer(0, 1, 2'b00, 32'h21, 32'h000000AA, 0, rd, lat);
        xfer(0, 0, 2'b10, 32'h20, 32'h0, 0, rd, lat);
        checks++;
        if (rd !== 32'hFFFFAAFF) begin errors++; $display("FAIL byte_lane_merge: got %h expected ffffaaff", rd); end
        xfer(0, 1, 2'b01, 32'h22, 32'hCDEF1234, 0, rd, lat);
        xfer(0, 0, 2'b10, 32'h20, 32'h0, 0, rd, lat);
        checks++;
        if (rd !== 32'h1234AAFF) begin errors++; $display("FAIL half_lane_merge: got %h expected 1234aaff", rd); end
    endtask
    task automatic test_errors();
        logic [31:0] rd;
        int lat;
        xfer(0, 1, 2'b10, 32'h13, 32'h12345678, 0, rd, lat);
        checks++;
        if (lat !== 3) begin errors++; $display("FAIL misaligned_acked: got latency %0d expected 3", lat); end
        checks++;
        if (err_v[0] !== 1'b1) begin errors++; $display("FAIL misaligned_err: got %b expected 1", err_v[0]); end
        xfer(0, 0, 2'b11, 32'h10, 32'h0, 0, rd, lat);
        checks++;
        if (lat !== 3 || rd !== 32'h0) begin
            errors++;
            $display("FAIL illegal_width: got latency %0d data %h expected 3 and 0", lat, rd);
        end
        xfer(0, 0, 2'b10, 32'h1000, 32'h0, 0, rd, lat);
        checks++;
        if (lat !== 3 || rd !== 32'h0) begin
            errors++;
            $display("FAIL out_of_range_rd: got latency %0d data %h expected 3 and 0", lat, rd);
        end
        xfer(0, 1, 2'b10, 32'h1010, 32'h0BADF00D, 0, rd, lat);
        xfer(0, 0, 2'b10, 32'h10, 32'h0, 0, rd, lat);
        checks++;
        if (rd !== 32'hDEADBEEF) begin errors++; $display("FAIL mem_unchanged: got %h expected deadbeef", rd); end
        checks++;
        if (err_v[0] !== 1'b1) begin errors++; $display("FAIL err_sticky: got %b expected 1", err_v[0]); end
        err_clr = 1'b1;
        @(posedge clk);
        #1;
        err_clr = 1'b0;
        checks++;
        if (err_v[0] !== 1'b0) begin errors++; $display("FAIL err_clear: got %b expected 0", err_v[0]); end
        addr = 32'h11;
        we = 1'b0;
        width = 2'b01;
        cyc_v[0] = 1'b1;
        stb_v[0] = 1'b1;
        @(posedge clk);
        #1;
        err_clr = 1'b1;
        @(posedge clk);
        #1;
        err_clr = 1'b0;
        cyc_v[0] = 1'b0;
        stb_v[0] = 1'b0;
        checks++;
        if (ack_v[0] !== 1'b1 || err_v[0] !== 1'b1) begin
            errors++;
            $display("FAIL set_beats_clear: got ack=%b err=%b expected 1 1", ack_v[0], err_v[0]);
        end
        @(posedge clk);
        #1;
        err_clr = 1'b1;
        @(posedge clk);
        #1;
        err_clr = 1'b0;
    endtask
    task automatic test_abort_reset();
        logic [31:0] rd;
        int lat, acks;
        xfer(1, 1, 2'b10, 32'h40, 32'h01020304, 0, rd, lat);
        checks++;
        if (lat !== 5) begin errors++; $display("FAIL ws3_latency: got %0d expected 5", lat); end
        addr = 32'h40;
        data_write = 32'hFFFFFFFF;
        we = 1'b1;
        width = 2'b10;
        cyc_v[1] = 1'b1;
        stb_v[1] = 1'b1;
        repeat (2) begin @(posedge clk); #1; end
        cyc_v[1] = 1'b0;
        stb_v[1] = 1'b0;
        acks = 0;
        repeat (6) begin @(negedge clk); if (ack_v[1]) acks++; end
        checks++;
        if (acks !== 0) begin errors++; $display("FAIL abort_no_ack: got %0d acks expected 0", acks); end
        @(posedge clk);
        #1;
        xfer(1, 0, 2'b10, 32'h40, 32'h0, 0, rd, lat);
        checks++;
        if (rd !== 32'h01020304) begin errors++; $display("FAIL abort_no_write: got %h expected 01020304", rd); end
        addr = 32'h44;
        we = 1'b1;
        cyc_v[1] = 1'b1;
        stb_v[1] = 1'b1;
        @(posedge clk);
        #1;
        @(negedge clk);
        rst_n = 1'b0;
        cyc_v[1] = 1'b0;
        stb_v[1] = 1'b0;
        #1;
        checks++;
        if (ack_v[1] !== 1'b0 || rd_v[1] !== 32'h0) begin
            errors++;
            $display("FAIL reset_mid_wait: got ack=%b rd=%h expected 0 0", ack_v[1], rd_v[1]);
        end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        acks = 0;
        repeat (6) begin @(negedge clk); if (ack_v[1]) acks++; end
        checks++;
        if (acks !== 0) begin errors++; $display("FAIL idle_after_reset: got %0d acks expected 0", acks); end
        @(posedge clk);
        #1;
        addr = 32'h40;
        we = 1'b0;
        cyc_v[1] = 1'b1;
        stb_v[1] = 1'b1;
        lat = 0;
        do begin @(negedge clk); lat++; end while (!ack_v[1] && lat < 40);
        checks++;
        if (lat !== 5 || rd_v[1] !== 32'h01020304) begin
            errors++;
            $display("FAIL read_after_reset: got latency %0d data %h expected 5 01020304", lat, rd_v[1]);
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if (ack_v[1] !== 1'b0 || rd_v[1] !== 32'h0) begin
            errors++;
            $display("FAIL reset_mid_ack: got ack=%b rd=%h expected 0 0", ack_v[1], rd_v[1]);
        end
        cyc_v[1] = 1'b0;
        stb_v[1] = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask
    task automatic test_back_to_back();
        logic [31:0] rd;
        int lat;
        for (int i = 0; i < 4; i++) begin
            xfer(2, 1, 2'b10, 32'h80 + 32'(4 * i), 32'hA0B0C000 + 32'(i), 1, rd, lat);
            checks++;
            if (lat !== 2) begin errors++; $display("FAIL b2b_wr%0d_period: got %0d expected 2", i, lat); end
        end
        for (int i = 0; i < 4; i++) begin
            xfer(2, 0, 2'b10, 32'h80 + 32'(4 * i), 32'h0, i != 3, rd, lat);
            checks++;
            if (lat !== 2 || rd !== 32'hA0B0C000 + 32'(i)) begin
                errors++;
                $display("FAIL b2b_rd%0d: got period %0d data %h expected 2 %h", i, lat, rd, 32'hA0B0C000 + 32'(i));
            end
        end
    endtask
    initial begin
        test_reset();
        test_word();
        test_bytes();
        test_lanes();
        test_errors();
        test_abort_reset();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
